mark28277: RTL and testbench

Top-level TinyTapeout user block. It is a 4-tap signed 8-bit dot-product engine, a single neuron of a tiny inference datapath. Weights are loaded serially over the dedicated inputs and activations are streamed in. After every fourth activation the block outputs a scaled, saturated and optionally rectified 8-bit result. It sits directly under the TinyTapeout harness, and all pins follow the standard tt_um pinout.

---
 rtl/mark28277.sv | 189 ++++++++++++++++++
 tb/tb_mark28277.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mark28277.sv
// mark28277 - TinyTapeout user block: a single 4-tap signed 8-bit neuron.
//
// Weights are loaded serially into a 4-entry register file. Activations are
// streamed in and multiplied against the weight selected by the activation
// pointer. The products are summed in an 18-bit accumulator. Every fourth
// activation closes a group. The sum is then arithmetically shifted by SHIFT,
// saturated to a signed byte and latched as the result.
//
// Build option:
//   RELU_EN  when defined, negative saturated results are clamped to zero.
//            When undefined, the signed saturated byte is output as-is.
//
// Command byte on uio_in: bit0 = valid, bits[2:1] = op.
//   00 LOAD   w[wp] <= ui_in, wp advances (wraps)
//   01 PUSH   multiply-accumulate ui_in against w[ap], ap advances
//   10 CLEAR  drop partial sum, rewind both pointers, clear result-valid
//   11 READ   show w[ui_in[1:0]] on uo_out until the next command
//
// rst_n keeps its harness name but is a synchronous, active-high reset.

module mark28277 #(
   parameter int SHIFT = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   // Command opcodes carried on uio_in[2:1]
   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_PUSH  = 2'b01;
   localparam logic [1:0] OP_CLEAR = 2'b10;
   localparam logic [1:0] OP_READ  = 2'b11;

   // Saturation bounds expressed at accumulator width
   localparam logic signed [17:0] SAT_MAX = 18'sd127;
   localparam logic signed [17:0] SAT_MIN = -18'sd128;

   // Architectural state
   logic signed [7:0]  w_q [4];
   logic signed [7:0]  w_d [4];
   logic [1:0]         wp_q, wp_d;
   logic [1:0]         ap_q, ap_d;
   logic signed [17:0] acc_q, acc_d;
   logic [7:0]         res_q, res_d;
   logic               done_q, done_d;
   logic               rv_q, rv_d;

   // Readback path: the latched weight byte and a flag that selects it
   logic [7:0]         readVal_q, readVal_d;
   logic               showRead_q, showRead_d;

   // Command decode
   logic               cmdValid;
   logic [1:0]         cmdOp;
   logic               cmdFire;

   // Datapath intermediates
   logic signed [15:0] product;
   logic signed [17:0] productExt;
   logic signed [17:0] groupSum;
   logic signed [17:0] shifted;
   logic signed [7:0]  saturated;
   logic [7:0]         finalByte;

   // uio_in[7:3] carry no meaning for this block
   logic               unusedBits;

   assign cmdValid   = uio_in[0];
   assign cmdOp      = uio_in[2:1];
   assign cmdFire    = ena & cmdValid;
   assign unusedBits = ^uio_in[7:3];

   // Multiply the incoming activation by the weight at the activation pointer
   always_comb begin
      product    = $signed(w_q[ap_q]) * $signed(ui_in);
      productExt = {{2{product[15]}}, product};
      groupSum   = acc_q + productExt;
   end

   // Scale the completed group sum, then saturate and optionally rectify it
   always_comb begin
      shifted = groupSum >>> SHIFT;
      if (shifted > SAT_MAX) begin
         saturated = 8'sd127;
      end else if (shifted < SAT_MIN) begin
         saturated = -8'sd128;
      end else begin
         saturated = shifted[7:0];
      end
`ifdef RELU_EN
      finalByte = saturated[7] ? 8'h00 : saturated;
`else
      finalByte = saturated;
`endif
   end

   // Next-state logic for all commands; done is a one-cycle pulse by default
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         w_d[i] = w_q[i];
      end
      wp_d       = wp_q;
      ap_d       = ap_q;
      acc_d      = acc_q;
      res_d      = res_q;
      done_d     = 1'b0;
      rv_d       = rv_q;
      readVal_d  = readVal_q;
      showRead_d = showRead_q;

      if (cmdFire) begin
         showRead_d = 1'b0;
         case (cmdOp)
            OP_LOAD: begin
               w_d[wp_q] = ui_in;
               wp_d      = wp_q + 2'd1;
            end
            OP_PUSH: begin
               if (ap_q != 2'd3) begin
                  acc_d = groupSum;
                  ap_d  = ap_q + 2'd1;
               end else begin
                  res_d  = finalByte;
                  acc_d  = '0;
                  ap_d   = 2'd0;
                  done_d = 1'b1;
                  rv_d   = 1'b1;
               end
            end
            OP_CLEAR: begin
               acc_d = '0;
               ap_d  = 2'd0;
               wp_d  = 2'd0;
               rv_d  = 1'b0;
            end
            OP_READ: begin
               readVal_d  = w_q[ui_in[1:0]];
               showRead_d = 1'b1;
            end
            default: begin
               showRead_d = 1'b0;
            end
         endcase
      end
   end

   // Register update with synchronous reset taking priority over any command
   always_ff @(posedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 4; i++) begin
            w_q[i] <= '0;
         end
         wp_q       <= '0;
         ap_q       <= '0;
         acc_q      <= '0;
         res_q      <= '0;
         done_q     <= 1'b0;
         rv_q       <= 1'b0;
         readVal_q  <= '0;
         showRead_q <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            w_q[i] <= w_d[i];
         end
         wp_q       <= wp_d;
         ap_q       <= ap_d;
         acc_q      <= acc_d;
         res_q      <= res_d;
         done_q     <= done_d;
         rv_q       <= rv_d;
         readVal_q  <= readVal_d;
         showRead_q <= showRead_d;
      end
   end

   // Drive the pins: result or readback byte, plus status on the upper uio bits
   always_comb begin
      uo_out  = showRead_q ? readVal_q : res_q;
      uio_out = {ap_q, rv_q, done_q, 3'b000, unusedBits & 1'b0};
      uio_oe  = 8'hF0;
   end

endmodule

// File: tb/tb_mark28277.sv
// tb_mark28277 - self-checking bench for the mark28277 neuron block.
// Directed scenarios followed by a randomized command stream. Both are compared
// against an arithmetic reference model of the neuron.

module tb_mark28277;

   localparam int SHIFT = 4;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int testsRun  = 0;
   int failCount = 0;

   // Reference model state
   int mW [4];
   int mWp, mAp, mAcc, mRes, mDone, mRv, mReadMode, mReadIdx;

   mark28277 #(.SHIFT(SHIFT)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .ena    (ena),
      .ui_in  (ui_in),
      .uio_in (uio_in),
      .uo_out (uo_out),
      .uio_out(uio_out),
      .uio_oe (uio_oe)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Floor-divide the group sum by 2^SHIFT, then clip and optionally rectify it
   function automatic int scaleResult(input int s);
      int div;
      int t;
      div = 1 << SHIFT;
      if (s >= 0) t = s / div;
      else        t = -((-s + div - 1) / div);
      if (t > 127)  t = 127;
      if (t < -128) t = -128;
`ifdef RELU_EN
      if (t < 0) t = 0;
`endif
      return t & 255;
   endfunction

   // Advance the model by one clock edge
   task automatic modelStep(input logic r, input logic e, input logic v,
                            input logic [1:0] op, input logic [7:0] d);
      int sd;
      int p;
      sd    = $signed(d);
      mDone = 0;
      if (r) begin
         for (int i = 0; i < 4; i++) mW[i] = 0;
         mWp = 0; mAp = 0; mAcc = 0; mRes = 0; mRv = 0;
         mReadMode = 0; mReadIdx = 0;
      end else if (e && v) begin
         mReadMode = 0;
         case (op)
            2'b00: begin
               mW[mWp] = sd;
               mWp = (mWp + 1) % 4;
            end
            2'b01: begin
               p = mW[mAp] * sd;
               if (mAp != 3) begin
                  mAcc += p;
                  mAp++;
               end else begin
                  mRes  = scaleResult(mAcc + p);
                  mAcc  = 0;
                  mAp   = 0;
                  mDone = 1;
                  mRv   = 1;
               end
            end
            2'b10: begin
               mAcc = 0; mAp = 0; mWp = 0; mRv = 0;
            end
            default: begin
               mReadMode = 1;
               mReadIdx  = d & 3;
            end
         endcase
      end
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         failCount++;
         $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, advance the model, and compare all outputs
   task automatic applyStimulus(input string tag, input logic r, input logic e,
                                input logic v, input logic [1:0] op,
                                input logic [7:0] d);
      logic [7:0] expUo;
      logic [7:0] expUio;
      rst_n  = r;
      ena    = e;
      uio_in = {5'b00000, op, v};
      ui_in  = d;
      @(posedge clk);
      modelStep(r, e, v, op, d);
      #1;
      expUo  = 8'((mReadMode != 0) ? (mW[mReadIdx] & 255) : mRes);
      expUio = 8'((mAp << 6) | (mRv << 5) | (mDone << 4));
      checkOutput({tag, ":uo_out"}, uo_out, expUo);
      checkOutput({tag, ":uio_out"}, uio_out, expUio);
      checkOutput({tag, ":uio_oe"}, uio_oe, 8'hF0);
   endtask

   task automatic doReset();
      applyStimulus("reset", 1'b1, 1'b1, 1'b0, 2'b00, 8'h00);
   endtask
   task automatic load(input logic [7:0] d);
      applyStimulus("load", 1'b0, 1'b1, 1'b1, 2'b00, d);
   endtask
   task automatic push(input logic [7:0] d);
      applyStimulus("push", 1'b0, 1'b1, 1'b1, 2'b01, d);
   endtask
   task automatic clear();
      applyStimulus("clear", 1'b0, 1'b1, 1'b1, 2'b10, 8'h00);
   endtask
   task automatic readW(input logic [7:0] idx);
      applyStimulus("read", 1'b0, 1'b1, 1'b1, 2'b11, idx);
   endtask
   task automatic idle();
      applyStimulus("idle", 1'b0, 1'b1, 1'b0, 2'b00, 8'h00);
   endtask

   initial begin
      logic [7:0] rd;
      logic [1:0] rop;
      logic       rr, re, rv;

      rst_n  = 1'b1;
      ena    = 1'b0;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      for (int i = 0; i < 4; i++) mW[i] = 0;
      mWp = 0; mAp = 0; mAcc = 0; mRes = 0; mDone = 0; mRv = 0;
      mReadMode = 0; mReadIdx = 0;

      // Reset state
      doReset();
      doReset();
      checkOutput("rst_uo", uo_out, 8'h00);
      checkOutput("rst_uio", uio_out, 8'h00);

      // Weights 1..4, activations 16: sum 160, shifted to 10
      load(8'd1); load(8'd2); load(8'd3); load(8'd4);
      push(8'd16); push(8'd16); push(8'd16); push(8'd16);
      checkOutput("tp1_res", uo_out, 8'h0A);
      checkOutput("tp1_done", {7'b0, uio_out[4]}, 8'h01);
      idle();
      checkOutput("tp1_done_drop", {7'b0, uio_out[4]}, 8'h00);
      checkOutput("tp1_rv_hold", {7'b0, uio_out[5]}, 8'h01);

      // All weights -1: sum -64, shifted to -4
      load(8'hFF); load(8'hFF); load(8'hFF); load(8'hFF);
      push(8'd16); push(8'd16); push(8'd16); push(8'd16);
`ifdef RELU_EN
      checkOutput("tp2_neg", uo_out, 8'h00);
`else
      checkOutput("tp2_neg", uo_out, 8'hFC);
`endif

      // Positive saturation, then back-to-back negative saturation
      load(8'd127); load(8'd127); load(8'd127); load(8'd127);
      push(8'd127); push(8'd127); push(8'd127); push(8'd127);
      checkOutput("tp3_satpos", uo_out, 8'h7F);
      load(8'h80); load(8'h80); load(8'h80); load(8'h80);
      push(8'd127); push(8'd127); push(8'd127); push(8'd127);
`ifdef RELU_EN
      checkOutput("tp3_satneg", uo_out, 8'h00);
`else
      checkOutput("tp3_satneg", uo_out, 8'h80);
`endif

      // Reset mid-group discards the partial sum and the weights
      load(8'd9); load(8'd9); load(8'd9); load(8'd9);
      push(8'd16); push(8'd16);
      doReset();
      readW(8'd1);
      checkOutput("tp4_wcleared", uo_out, 8'h00);
      load(8'd1); load(8'd2); load(8'd3); load(8'd4);
      push(8'd16); push(8'd16); push(8'd16); push(8'd16);
      checkOutput("tp4_res", uo_out, 8'h0A);

      // ena low ignores commands; READ 2 then returns the loaded weight
      load(8'd5); load(8'd6); load(8'd7); load(8'd8);
      applyStimulus("ena0_load", 1'b0, 1'b0, 1'b1, 2'b00, 8'd99);
      applyStimulus("ena0_push", 1'b0, 1'b0, 1'b1, 2'b01, 8'd50);
      applyStimulus("ena0_clear", 1'b0, 1'b0, 1'b1, 2'b10, 8'd0);
      readW(8'd2);
      checkOutput("tp5_read", uo_out, 8'h07);

      // CLEAR after two pushes restarts from a fresh accumulator
      push(8'd16); push(8'd16);
      clear();
      checkOutput("tp6_ap", {6'b0, uio_out[7:6]}, 8'h00);
      checkOutput("tp6_rv", {7'b0, uio_out[5]}, 8'h00);
      push(8'd16); push(8'd16); push(8'd16); push(8'd16);
      checkOutput("tp6_res", uo_out, 8'h1A);

      // Randomized command stream
      for (int n = 0; n < 400; n++) begin
         rr  = ($urandom_range(0, 39) == 0);
         re  = ($urandom_range(0, 9) != 0);
         rv  = ($urandom_range(0, 9) < 7);
         rop = 2'($urandom_range(0, 3));
         rd  = 8'($urandom);
         applyStimulus("rand", rr, re, rv, rop, rd);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
